// File: rtl/ascon_pkg.sv
// ascon_pkg: shared definitions for the Ascon plaintext collector.
//   collState_e : FSM state encoding used by ascon_pt_collector
//   ASCON_TAGW  : Ascon tag width (128 bits)
//   max2()      : constant-foldable maximum, used for parameter defaults
package ascon_pkg;

  localparam int ASCON_TAGW = 128;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_CHECK   = 3'd3,
    ST_HOLD    = 3'd4
  } collState_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ascon_sipo.sv
// ascon_sipo: width-W serial-to-parallel register. Each cycle with writeEn
// high, bitIn is written to bit position idx (LSB-first streams simply count
// idx up from 0). Indices at or beyond W are ignored, so a shorter register
// can share an index counter with a longer one.
// Ports:
//   clk     in  1   clock
//   rst     in  1   synchronous active-high reset, clears q
//   writeEn in  1   write bitIn at position idx this cycle
//   idx     in  IW  bit position
//   bitIn   in  1   serial data
//   q       out W   parallel contents
module ascon_sipo #(
  parameter int W  = 128,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          writeEn,
  input  logic [IW-1:0] idx,
  input  logic          bitIn,
  output logic [W-1:0]  q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      for (int b = 0; b < W; b++) begin
        if (writeEn && (idx == IW'(b))) q[b] <= bitIn;
      end
    end
  end

endmodule

// File: rtl/ascon_pt_collector.sv
// ascon_pt_collector: collects the serial plaintext and tag streams of the
// serial Ascon decryption core, checks the tag and hands the plaintext to a
// consumer over valid/ready. Plaintext is released only when the tag matches.
//
//   state   | meaning
//   IDLE    | waiting for a rising edge on decryption_readyxSI
//   WAIT    | SKIP settle cycles before the first stream bit
//   CAPTURE | N cycles shifting in plaintext and tag, LSB first
//   CHECK   | one-cycle full-width tag compare, result registered
//   HOLD    | result presented until validxSO & readyxSI
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   decryption_readyxSI  core done strobe (rising edge starts a collection)
//   plain_textxSI        serial plaintext
//   tagxSI               serial computed tag
//   expected_tagxDI      received tag, stable until validxSO
//   readyxSI             consumer accepts the result
//   ptxDO                parallel plaintext, zero unless auth_okxSO
//   tagxDO               last captured computed tag
//   validxSO             result available
//   auth_okxSO           computed tag equals expected_tagxDI
//   busyxSO              high in WAIT, CAPTURE and CHECK
//   overrunxSO           sticky: ready edge arrived outside IDLE
module ascon_pt_collector
  import ascon_pkg::*;
#(
  parameter int Y    = 80,
  parameter int TAGW = ASCON_TAGW,
  parameter int N    = max2(Y, TAGW),
  parameter int SKIP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            decryption_readyxSI,
  input  logic            plain_textxSI,
  input  logic            tagxSI,
  input  logic [TAGW-1:0] expected_tagxDI,
  input  logic            readyxSI,
  output logic [Y-1:0]    ptxDO,
  output logic [TAGW-1:0] tagxDO,
  output logic            validxSO,
  output logic            auth_okxSO,
  output logic            busyxSO,
  output logic            overrunxSO
);

  localparam int CW = $clog2(max2(N, SKIP) + 1);

  localparam logic [2:0] IDLE    = ST_IDLE;
  localparam logic [2:0] WAIT    = ST_WAIT;
  localparam logic [2:0] CAPTURE = ST_CAPTURE;
  localparam logic [2:0] CHECK   = ST_CHECK;
  localparam logic [2:0] HOLD    = ST_HOLD;

  logic [2:0]      state;
  logic [CW-1:0]   cnt;
  logic            rdyQ;
  logic            rdyEdge;
  logic            capEn;
  logic            tagMatch;
  logic [Y-1:0]    ptSr;
  logic [TAGW-1:0] tagSr;

  assign rdyEdge  = decryption_readyxSI & ~rdyQ;
  assign capEn    = (state == CAPTURE);
  // Single full-width equality: no early exit on the first differing bit.
  assign tagMatch = (tagSr == expected_tagxDI);
  assign busyxSO  = (state == WAIT) || (state == CAPTURE) || (state == CHECK);

  // Both registers share the capture counter as bit index; the shorter one
  // ignores indices past its width.
  ascon_sipo #(.W(Y), .IW(CW)) uPtSipo (
    .clk     (clk),
    .rst     (rst),
    .writeEn (capEn),
    .idx     (cnt),
    .bitIn   (plain_textxSI),
    .q       (ptSr)
  );

  ascon_sipo #(.W(TAGW), .IW(CW)) uTagSipo (
    .clk     (clk),
    .rst     (rst),
    .writeEn (capEn),
    .idx     (cnt),
    .bitIn   (tagxSI),
    .q       (tagSr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rdyQ       <= 1'b0;
      validxSO   <= 1'b0;
      auth_okxSO <= 1'b0;
      ptxDO      <= '0;
      tagxDO     <= '0;
      overrunxSO <= 1'b0;
    end else begin
      rdyQ <= decryption_readyxSI;
      // Edges outside IDLE are dropped, only flagged.
      if (rdyEdge && (state != IDLE)) overrunxSO <= 1'b1;

      case (state)
        IDLE: begin
          if (rdyEdge) begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CW'(SKIP - 1)) begin
            cnt   <= '0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CAPTURE: begin
          if (cnt == CW'(N - 1)) begin
            cnt   <= '0;
            state <= CHECK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          auth_okxSO <= tagMatch;
          ptxDO      <= tagMatch ? ptSr : '0;
          tagxDO     <= tagSr;
          validxSO   <= 1'b1;
          cnt        <= '0;
          state      <= HOLD;
        end
        HOLD: begin
          if (readyxSI) begin
            validxSO   <= 1'b0;
            auth_okxSO <= 1'b0;
            ptxDO      <= '0;
            cnt        <= '0;
            state      <= IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_pt_collector.sv
module tb_ascon_pt_collector;

  localparam int SKIP = 4;
  localparam int N    = 128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         decRdy = 1'b0;
  logic         ptIn = 1'b0;
  logic         tagIn = 1'b0;
  logic [127:0] expTag = '0;
  logic         rdyIn = 1'b0;

  logic [79:0]  pt80;
  logic [127:0] tag80;
  logic         valid80, ok80, busy80, ovr80;
  logic [39:0]  pt40;
  logic [127:0] tag40;
  logic         valid40, ok40, busy40, ovr40;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ascon_pt_collector #(.Y(80), .SKIP(SKIP)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .decryption_readyxSI (decRdy),
    .plain_textxSI       (ptIn),
    .tagxSI              (tagIn),
    .expected_tagxDI     (expTag),
    .readyxSI            (rdyIn),
    .ptxDO               (pt80),
    .tagxDO              (tag80),
    .validxSO            (valid80),
    .auth_okxSO          (ok80),
    .busyxSO             (busy80),
    .overrunxSO          (ovr80)
  );

  ascon_pt_collector #(.Y(40), .SKIP(SKIP)) dut40 (
    .clk                 (clk),
    .rst                 (rst),
    .decryption_readyxSI (decRdy),
    .plain_textxSI       (ptIn),
    .tagxSI              (tagIn),
    .expected_tagxDI     (expTag),
    .readyxSI            (rdyIn),
    .ptxDO               (pt40),
    .tagxDO              (tag40),
    .validxSO            (valid40),
    .auth_okxSO          (ok40),
    .busyxSO             (busy40),
    .overrunxSO          (ovr40)
  );

  typedef struct {
    logic [79:0]  pt;
    logic [127:0] tag;
    logic [127:0] expTag;
    int           bp;
    bit           tieRdy;
    bit           expOk;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entered just after a negedge, returns just after a negedge.
  // mode 0: single ready pulse; mode 1: ready held high with an extra pulse
  // during capture.
  task automatic runTxn(input logic [79:0] pt, input logic [127:0] tg,
                        input logic [127:0] et, input bit ok,
                        input int bp, input bit tieRdy, input int mode);
    bit timingBad = 0;
    bit stableBad = 0;
    logic [79:0]  snapPt;
    logic [127:0] snapTag;
    logic [79:0]  wantPt;
    logic [39:0]  wantPt40;
    wantPt   = ok ? pt : '0;
    wantPt40 = ok ? pt[39:0] : '0;
    expTag = et;
    decRdy = 1'b1;
    rdyIn  = tieRdy;
    @(posedge clk);
    for (int k = 0; k < SKIP + N; k++) begin
      @(negedge clk);
      if (mode == 0 && k == 0) decRdy = 1'b0;
      if (mode == 1 && k == SKIP + 20) decRdy = 1'b0;
      if (mode == 1 && k == SKIP + 21) decRdy = 1'b1;
      if (!busy80 || valid80 || !busy40 || valid40) timingBad = 1;
      if (k >= SKIP) begin
        tagIn = tg[k - SKIP];
        ptIn  = (k - SKIP < 80) ? pt[k - SKIP] : 1'($urandom);
      end else begin
        tagIn = 1'($urandom);
        ptIn  = 1'($urandom);
      end
    end
    @(negedge clk);
    ptIn = 1'($urandom); tagIn = 1'($urandom);
    chk("busyDuringRun", {127'b0, timingBad}, 128'd0);
    chk("validEarly", {127'b0, valid80}, 128'd0);
    @(negedge clk);
    chk("validLatency", {127'b0, valid80}, 128'd1);
    chk("validLatency40", {127'b0, valid40}, 128'd1);
    chk("authOk", {127'b0, ok80}, {127'b0, ok});
    chk("authOk40", {127'b0, ok40}, {127'b0, ok});
    chk("pt", {48'b0, pt80}, {48'b0, wantPt});
    chk("pt40", {88'b0, pt40}, {88'b0, wantPt40});
    chk("tag", tag80, tg);
    chk("tag40", tag40, tg);
    chk("busyInHold", {127'b0, busy80}, 128'd0);
    if (!tieRdy) begin
      snapPt = pt80; snapTag = tag80;
      for (int c = 0; c < bp; c++) begin
        @(negedge clk);
        if (!valid80 || pt80 !== snapPt || tag80 !== snapTag || ok80 !== ok) stableBad = 1;
      end
      chk("holdStable", {127'b0, stableBad}, 128'd0);
      rdyIn = 1'b1;
    end
    @(negedge clk);
    rdyIn = 1'b0;
    chk("validFall", {127'b0, valid80}, 128'd0);
    chk("ptCleared", {48'b0, pt80}, 128'd0);
    chk("authCleared", {127'b0, ok80}, 128'd0);
    chk("tagKept", tag80, tg);
  endtask

  vec_t vecs[7];

  initial begin
    logic [127:0] tSpec;
    logic [79:0]  pSpec;
    bit idleBad;
    tSpec = 128'h00112233445566778899aabbccddeeff;
    pSpec = 80'h0123456789abcdef0123;
    vecs[0] = '{pSpec, tSpec, tSpec, 0, 1'b0, 1'b1};
    vecs[1] = '{pSpec, tSpec, tSpec ^ (128'd1 << 77), 0, 1'b0, 1'b0};
    vecs[2] = '{pSpec, tSpec, tSpec, 10, 1'b0, 1'b1};
    vecs[3] = '{{80{1'b1}}, {128{1'b1}}, {128{1'b1}}, 0, 1'b1, 1'b1};
    vecs[4] = '{80'h55555_aaaaa_55555_aaaaa, 128'd0, 128'd1, 0, 1'b1, 1'b0};
    vecs[5] = '{80'hfedcba98765432100f0f, tSpec, tSpec ^ (128'd1 << 127), 3, 1'b0, 1'b0};
    vecs[6] = '{80'h8000000000000000_0001, 128'h80000000_00000000_00000000_00000001,
                128'h80000000_00000000_00000000_00000001, 0, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    chk("rstValid", {127'b0, valid80}, 128'd0);
    chk("rstPt", {48'b0, pt80}, 128'd0);
    chk("rstTag", tag80, 128'd0);
    chk("rstBusyOvr", {126'b0, busy80, ovr80}, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++)
      runTxn(vecs[v].pt, vecs[v].tag, vecs[v].expTag, vecs[v].expOk,
             vecs[v].bp, vecs[v].tieRdy, 0);
    chk("noOverrunYet", {127'b0, ovr80}, 128'd0);

    // Level hold with an extra pulse during capture.
    runTxn(pSpec, tSpec, tSpec, 1'b1, 2, 1'b0, 1);
    chk("overrunSet", {127'b0, ovr80}, 128'd1);
    chk("overrunSet40", {127'b0, ovr40}, 128'd1);
    idleBad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy80 || valid80) idleBad = 1;
    end
    chk("noRetrigger", {127'b0, idleBad}, 128'd0);
    decRdy = 1'b0;
    @(negedge clk);
    runTxn(~pSpec, ~tSpec, ~tSpec, 1'b1, 1, 1'b0, 0);
    chk("overrunSticky", {127'b0, ovr80}, 128'd1);

    // Reset while bit 40 is being captured.
    decRdy = 1'b1;
    @(posedge clk);
    for (int k = 0; k < SKIP + 40; k++) begin
      @(negedge clk);
      if (k == 0) decRdy = 1'b0;
      ptIn = 1'($urandom); tagIn = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midRstValidBusy", {126'b0, valid80, busy80}, 128'd0);
    chk("midRstPt", {48'b0, pt80}, 128'd0);
    chk("midRstTag", tag80, 128'd0);
    chk("midRstOvr", {126'b0, ovr80, ok80}, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    runTxn(pSpec, tSpec, tSpec, 1'b1, 0, 1'b0, 0);

    // Randomized transactions against the reference rules.
    for (int r = 0; r < 30; r++) begin
      logic [95:0]  r96;
      logic [127:0] tg, et;
      r96 = {$urandom, $urandom, $urandom};
      tg  = {$urandom, $urandom, $urandom, $urandom};
      et  = tg;
      if ($urandom_range(0, 2) == 0) et[$urandom_range(0, 127)] ^= 1'b1;
      runTxn(r96[79:0], tg, et, (tg == et), int'($urandom_range(0, 5)),
             1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
